// File: rtl/id_ex_fwd_stage.sv
// id_ex_fwd_stage
//   This is the ID/EX pipeline register, EX-stage operand forwarding and
//   load-use hazard detection.
//   Inputs : clk, rst_n (sync, active low), stall, flush, id_* decoded fields,
//            exmem_*/memwb_* forwarding sources.
//   Outputs: rsdata / rtdataOrextimm / ALUctrl go to the ALU.
//            ex_storedata, ex_dest and ex_* ctrl go to EX/MEM.
//            load_use (combinational) freezes PC and IF/ID.

// fwd_sel: forwarding mux for one source operand.
//   Priority is EX/MEM (younger) over MEM/WB over the register-file value.
//   Register 0 is never forwarded.
module fwd_sel #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] src,
  input  logic [DATA_W-1:0] regdata,
  input  logic              exmem_regwrite,
  input  logic [REG_AW-1:0] exmem_rd,
  input  logic [DATA_W-1:0] exmem_result,
  input  logic              memwb_regwrite,
  input  logic [REG_AW-1:0] memwb_rd,
  input  logic [DATA_W-1:0] memwb_result,
  output logic [DATA_W-1:0] data
);
  logic hit_exmem, hit_memwb;

  assign hit_exmem = exmem_regwrite && (exmem_rd != '0) && (exmem_rd == src);
  assign hit_memwb = memwb_regwrite && (memwb_rd != '0) && (memwb_rd == src);

  always_comb begin
    data = regdata;
    if (hit_exmem)      data = exmem_result;
    else if (hit_memwb) data = memwb_result;
  end
endmodule

module id_ex_fwd_stage #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int CTRL_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              flush,
  input  logic              id_valid,
  input  logic [DATA_W-1:0] id_rsdata,
  input  logic [DATA_W-1:0] id_rtdata,
  input  logic [DATA_W-1:0] id_extimm,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic [REG_AW-1:0] id_rd,
  input  logic [CTRL_W-1:0] id_aluctrl,
  input  logic              id_alusrc,
  input  logic              id_regdst,
  input  logic              id_regwrite,
  input  logic              id_memread,
  input  logic              id_memwrite,
  input  logic              id_memtoreg,
  input  logic              id_branch,
  input  logic              exmem_regwrite,
  input  logic [REG_AW-1:0] exmem_rd,
  input  logic [DATA_W-1:0] exmem_result,
  input  logic              memwb_regwrite,
  input  logic [REG_AW-1:0] memwb_rd,
  input  logic [DATA_W-1:0] memwb_result,
  output logic [DATA_W-1:0] rsdata,
  output logic [DATA_W-1:0] rtdataOrextimm,
  output logic [CTRL_W-1:0] ALUctrl,
  output logic [DATA_W-1:0] ex_storedata,
  output logic [REG_AW-1:0] ex_dest,
  output logic              ex_valid,
  output logic              ex_regwrite,
  output logic              ex_memread,
  output logic              ex_memwrite,
  output logic              ex_memtoreg,
  output logic              ex_branch,
  output logic              load_use
);
  typedef struct packed {
    logic              valid;
    logic [DATA_W-1:0] rsdata;
    logic [DATA_W-1:0] rtdata;
    logic [DATA_W-1:0] extimm;
    logic [REG_AW-1:0] rs;
    logic [REG_AW-1:0] rt;
    logic [REG_AW-1:0] dest;
    logic [CTRL_W-1:0] aluctrl;
    logic              alusrc;
    logic              regwrite;
    logic              memread;
    logic              memwrite;
    logic              memtoreg;
    logic              branch;
  } idex_t;

  idex_t ex_q, id_pkt;

  // An all-zero packet is the bubble.  Because its rs/rt fields are also 0,
  // a bubble can never pick up a forwarded value.
  always_comb begin
    id_pkt          = '0;
    id_pkt.valid    = 1'b1;
    id_pkt.rsdata   = id_rsdata;
    id_pkt.rtdata   = id_rtdata;
    id_pkt.extimm   = id_extimm;
    id_pkt.rs       = id_rs;
    id_pkt.rt       = id_rt;
    id_pkt.dest     = id_regdst ? id_rd : id_rt;
    id_pkt.aluctrl  = id_aluctrl;
    id_pkt.alusrc   = id_alusrc;
    id_pkt.regwrite = id_regwrite;
    id_pkt.memread  = id_memread;
    id_pkt.memwrite = id_memwrite;
    id_pkt.memtoreg = id_memtoreg;
    id_pkt.branch   = id_branch;
  end

  assign load_use = ex_q.valid && ex_q.memread && (ex_q.dest != '0) &&
                    ((ex_q.dest == id_rs) || (ex_q.dest == id_rt));

  // flush beats stall.  stall holds even across a load-use; the hazard is
  // re-evaluated when the stall releases.
  always_ff @(posedge clk) begin
    if (!rst_n)        ex_q <= '0;
    else if (flush)    ex_q <= '0;
    else if (stall)    ex_q <= ex_q;
    else if (load_use) ex_q <= '0;
    else if (id_valid) ex_q <= id_pkt;
    else               ex_q <= '0;
  end

  // Operand 0 = rs and operand 1 = rt.  Each operand has its own forwarding mux.
  logic [1:0][REG_AW-1:0] fsrc;
  logic [1:0][DATA_W-1:0] fin, fout;

  assign fsrc = {ex_q.rt, ex_q.rs};
  assign fin  = {ex_q.rtdata, ex_q.rsdata};

  for (genvar g = 0; g < 2; g++) begin : g_fwd
    fwd_sel #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd (
      .src            (fsrc[g]),
      .regdata        (fin[g]),
      .exmem_regwrite (exmem_regwrite),
      .exmem_rd       (exmem_rd),
      .exmem_result   (exmem_result),
      .memwb_regwrite (memwb_regwrite),
      .memwb_rd       (memwb_rd),
      .memwb_result   (memwb_result),
      .data           (fout[g])
    );
  end

  assign rsdata         = fout[0];
  assign ex_storedata   = fout[1];
  assign rtdataOrextimm = ex_q.alusrc ? ex_q.extimm : fout[1];
  assign ALUctrl        = ex_q.aluctrl;
  assign ex_dest        = ex_q.dest;
  assign ex_valid       = ex_q.valid;
  assign ex_regwrite    = ex_q.regwrite;
  assign ex_memread     = ex_q.memread;
  assign ex_memwrite    = ex_q.memwrite;
  assign ex_memtoreg    = ex_q.memtoreg;
  assign ex_branch      = ex_q.branch;
endmodule

// File: tb/tb_id_ex_fwd_stage.sv
module tb_id_ex_fwd_stage;
  logic        clk = 1'b0;
  logic        rst_n, stall, flush, id_valid;
  logic [31:0] id_rsdata, id_rtdata, id_extimm;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic [3:0]  id_aluctrl;
  logic        id_alusrc, id_regdst, id_regwrite, id_memread, id_memwrite, id_memtoreg, id_branch;
  logic        exmem_regwrite, memwb_regwrite;
  logic [4:0]  exmem_rd, memwb_rd;
  logic [31:0] exmem_result, memwb_result;
  logic [31:0] rsdata, rtdataOrextimm, ex_storedata;
  logic [3:0]  ALUctrl;
  logic [4:0]  ex_dest;
  logic        ex_valid, ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg, ex_branch, load_use;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  id_ex_fwd_stage dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .id_valid(id_valid),
    .id_rsdata(id_rsdata), .id_rtdata(id_rtdata), .id_extimm(id_extimm),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_aluctrl(id_aluctrl),
    .id_alusrc(id_alusrc), .id_regdst(id_regdst), .id_regwrite(id_regwrite),
    .id_memread(id_memread), .id_memwrite(id_memwrite), .id_memtoreg(id_memtoreg),
    .id_branch(id_branch),
    .exmem_regwrite(exmem_regwrite), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
    .memwb_regwrite(memwb_regwrite), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
    .rsdata(rsdata), .rtdataOrextimm(rtdataOrextimm), .ALUctrl(ALUctrl),
    .ex_storedata(ex_storedata), .ex_dest(ex_dest), .ex_valid(ex_valid),
    .ex_regwrite(ex_regwrite), .ex_memread(ex_memread), .ex_memwrite(ex_memwrite),
    .ex_memtoreg(ex_memtoreg), .ex_branch(ex_branch), .load_use(load_use)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic id_clear();
    id_valid = 0; id_rsdata = 0; id_rtdata = 0; id_extimm = 0;
    id_rs = 0; id_rt = 0; id_rd = 0; id_aluctrl = 0; id_alusrc = 0; id_regdst = 0;
    id_regwrite = 0; id_memread = 0; id_memwrite = 0; id_memtoreg = 0; id_branch = 0;
  endtask

  task automatic fwd_clear();
    exmem_regwrite = 0; exmem_rd = 0; exmem_result = 0;
    memwb_regwrite = 0; memwb_rd = 0; memwb_result = 0;
  endtask

  initial begin
    stall = 0; flush = 0; fwd_clear();
    // 1: reset with ID driving all-ones
    rst_n = 0;
    id_valid = 1; id_rsdata = '1; id_rtdata = '1; id_extimm = '1;
    id_rs = '1; id_rt = '1; id_rd = '1; id_aluctrl = '1; id_alusrc = 1; id_regdst = 1;
    id_regwrite = 1; id_memread = 1; id_memwrite = 1; id_memtoreg = 1; id_branch = 1;
    tick(); tick();
    chk("rst_rsdata", rsdata, 0);
    chk("rst_opb", rtdataOrextimm, 0);
    chk("rst_aluctrl", 32'(ALUctrl), 0);
    chk("rst_dest", 32'(ex_dest), 0);
    chk("rst_ctrl", {26'd0, ex_valid, ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg, ex_branch}, 0);
    chk("rst_storedata", ex_storedata, 0);
    chk("rst_load_use", 32'(load_use), 0);

    // 2: add $3,$1,$2 with operands 5 and 7
    rst_n = 1; id_clear();
    id_valid = 1; id_rs = 1; id_rt = 2; id_rd = 3; id_rsdata = 5; id_rtdata = 7;
    id_aluctrl = 4'b0010; id_regdst = 1; id_regwrite = 1;
    tick();
    id_clear(); #1;
    chk("add_rsdata", rsdata, 5);
    chk("add_opb", rtdataOrextimm, 7);
    chk("add_aluctrl", 32'(ALUctrl), 32'h2);
    chk("add_dest", 32'(ex_dest), 3);
    chk("add_valid_rw", {30'd0, ex_valid, ex_regwrite}, 32'h3);

    // 3: forwarding priority onto registered rs=1 and rt=2
    exmem_regwrite = 1; exmem_rd = 1; exmem_result = 32'hAA;
    memwb_regwrite = 1; memwb_rd = 1; memwb_result = 32'hBB;
    #1 chk("fwd_exmem_wins", rsdata, 32'hAA);
    exmem_rd = 0;
    #1 chk("fwd_exmem_r0_skip", rsdata, 32'hBB);
    memwb_rd = 0;
    #1 chk("fwd_none_r0", rsdata, 5);
    memwb_rd = 2;
    #1 chk("fwd_memwb_rt", rtdataOrextimm, 32'hBB);
    chk("fwd_memwb_store", ex_storedata, 32'hBB);
    memwb_regwrite = 0;
    #1 chk("fwd_memwb_norw", rtdataOrextimm, 7);
    fwd_clear();

    // 4: lw $4 then add using $4, which is a load-use hazard
    id_valid = 1; id_rt = 4; id_regdst = 0; id_memread = 1; id_regwrite = 1;
    id_memtoreg = 1; id_aluctrl = 4'b0010; id_extimm = 8; id_alusrc = 1;
    tick();
    id_clear();
    id_valid = 1; id_rs = 4; id_rt = 2; id_rd = 5; id_regdst = 1; id_regwrite = 1;
    id_rsdata = 32'h11; id_rtdata = 32'h22; id_aluctrl = 4'b0010;
    #1;
    chk("lu_dest", 32'(ex_dest), 4);
    chk("lu_asserted", 32'(load_use), 1);
    tick();
    chk("lu_bubble", {30'd0, ex_valid, ex_regwrite}, 0);
    chk("lu_cleared", 32'(load_use), 0);
    tick();
    chk("lu_add_dest", 32'(ex_dest), 5);
    chk("lu_add_rsdata", rsdata, 32'h11);
    chk("lu_add_valid", 32'(ex_valid), 1);

    // 5: stall for 3 cycles while ID changes, then flush over stall
    stall = 1;
    id_rd = 9; id_rsdata = 32'h99; id_aluctrl = 4'b0110;
    tick(); id_rs = 7; tick(); id_rd = 12; tick();
    chk("stall_dest", 32'(ex_dest), 5);
    chk("stall_aluctrl", 32'(ALUctrl), 32'h2);
    chk("stall_rsdata", rsdata, 32'h11);
    flush = 1;
    tick();
    chk("flush_bubble", {22'd0, ex_dest, ALUctrl, ex_valid}, 0);
    chk("flush_rw", 32'(ex_regwrite), 0);
    flush = 0; stall = 0;

    // 6: addi with a negative immediate and a store-data forward of rt=6
    id_clear();
    id_valid = 1; id_rt = 6; id_alusrc = 1; id_extimm = 32'hFFFF_FFFC;
    id_rtdata = 32'h33; id_regwrite = 1; id_aluctrl = 4'b0010;
    tick();
    id_clear();
    exmem_regwrite = 1; exmem_rd = 6; exmem_result = 32'h10;
    #1;
    chk("imm_opb", rtdataOrextimm, 32'hFFFF_FFFC);
    chk("imm_storedata", ex_storedata, 32'h10);
    chk("imm_dest", 32'(ex_dest), 6);
    fwd_clear();

    // A reset in the middle of a load-use clears the hazard on the next edge.
    id_valid = 1; id_rt = 8; id_memread = 1; id_regwrite = 1;
    tick();
    id_clear(); id_valid = 1; id_rt = 8;
    #1 chk("rst_lu_before", 32'(load_use), 1);
    rst_n = 0;
    tick();
    chk("rst_lu_after", 32'(load_use), 0);
    chk("rst_lu_valid", 32'(ex_valid), 0);
    rst_n = 1;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
